// File: rtl/inv_mix_columns_seq_if.sv
// rtl/inv_mix_columns_seq_if.sv - state in/out handshake bundle for inv_mix_columns_seq
interface inv_mix_columns_seq_if #(
  parameter int DATA_W = 128
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_bypass;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              busy;

  modport slave (
    input  in_valid, in_data, in_bypass, out_ready,
    output in_ready, out_valid, out_data, busy
  );

  modport master (
    output in_valid, in_data, in_bypass, out_ready,
    input  in_ready, out_valid, out_data, busy
  );
endinterface

// File: rtl/inv_mix_columns_seq.sv
// rtl/inv_mix_columns_seq.sv - column-serial AES InvMixColumns over one shared helper
module inv_mix_column_helper (
  input  logic [31:0] col,
  output logic [31:0] res
);
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  logic [7:0] a  [4];
  logic [7:0] m9 [4];
  logic [7:0] mb [4];
  logic [7:0] md [4];
  logic [7:0] me [4];

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      logic [7:0] x2, x4, x8;
      a[i]  = col[31-8*i -: 8];
      x2    = xt(a[i]);
      x4    = xt(x2);
      x8    = xt(x4);
      m9[i] = x8 ^ a[i];
      mb[i] = x8 ^ x2 ^ a[i];
      md[i] = x8 ^ x4 ^ a[i];
      me[i] = x8 ^ x4 ^ x2;
    end
    res[31:24] = me[0] ^ mb[1] ^ md[2] ^ m9[3];
    res[23:16] = m9[0] ^ me[1] ^ mb[2] ^ md[3];
    res[15:8]  = md[0] ^ m9[1] ^ me[2] ^ mb[3];
    res[7:0]   = mb[0] ^ md[1] ^ m9[2] ^ me[3];
  end
endmodule

module inv_mix_columns_seq #(
  parameter int NCOL  = 4,
  parameter int COL_W = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  inv_mix_columns_seq_if.slave   bus
);
  localparam int CNT_W = $clog2(NCOL);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   col_cnt;
  logic [COL_W-1:0]   src_cols [NCOL];
  logic [COL_W-1:0]   out_cols [NCOL];
  logic [COL_W-1:0]   helper_in;
  logic [COL_W-1:0]   helper_out;
  logic               out_valid;
  logic               accept;
  logic               last_col;
  logic               out_fire;

  inv_mix_column_helper u_helper (
    .col (helper_in),
    .res (helper_out)
  );

  // Column 0 lives in the most significant word of the 128-bit state.
  for (genvar g = 0; g < NCOL; g++) begin : g_cols
    assign bus.out_data[(NCOL-1-g)*COL_W +: COL_W] = out_cols[g];
  end

  assign helper_in     = src_cols[col_cnt];
  assign bus.in_ready  = rst_n && (state == IDLE);
  assign bus.out_valid = out_valid;
  assign bus.busy      = (state != IDLE);
  assign accept        = bus.in_valid && bus.in_ready;
  assign last_col      = (col_cnt == CNT_W'(NCOL-1));
  assign out_fire      = out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = bus.in_bypass ? DONE : BUSY;
      BUSY:    if (last_col) state_nxt = DONE;
      DONE:    if (out_fire) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bypass enters DONE with out_valid low, so the result appears one edge after accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_cnt   <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < NCOL; i++) begin
        src_cols[i] <= '0;
        out_cols[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            col_cnt <= '0;
            for (int i = 0; i < NCOL; i++) begin
              src_cols[i] <= bus.in_data[(NCOL-1-i)*COL_W +: COL_W];
              if (bus.in_bypass) out_cols[i] <= bus.in_data[(NCOL-1-i)*COL_W +: COL_W];
            end
          end
        end
        BUSY: begin
          out_cols[col_cnt] <= helper_out;
          if (last_col) begin
            col_cnt   <= '0;
            out_valid <= 1'b1;
          end else begin
            col_cnt <= col_cnt + CNT_W'(1);
          end
        end
        DONE: begin
          if (out_fire)        out_valid <= 1'b0;
          else if (!out_valid) out_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// tb/tb_inv_mix_columns_seq.sv - directed self-checking bench for inv_mix_columns_seq
module tb_inv_mix_columns_seq;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  inv_mix_columns_seq_if bus ();

  inv_mix_columns_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [127:0] V1_IN  = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] V1_OUT = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] V2_IN  = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
  localparam logic [127:0] V2_OUT = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
  localparam logic [127:0] V3_IN  = 128'h4d7ebdf8_d5d5d7d6_c6c6c6c6_01010101;
  localparam logic [127:0] V3_OUT = 128'h2d26314c_d4d4d4d5_c6c6c6c6_01010101;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Drives a state at a negedge, waits for in_ready, returns #1 after the accept edge.
  task automatic send(input string tag, input logic [127:0] d, input logic byp, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.in_data   = d;
    bus.in_bypass = byp;
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_accept_timeout"}, 128'(n < 50), 128'd1);
    @(posedge clk);
    #1;
    bus.in_bypass = ~byp;
    if (!hold) begin
      bus.in_valid = 1'b0;
      bus.in_data  = ~d;
    end
  endtask

  task automatic wait_out(input string tag, input int exp_lat, input logic [127:0] exp_data);
    int lat;
    lat = 0;
    while (!bus.out_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_latency"}, 128'(lat), 128'(exp_lat));
    chk({tag, "_data"}, bus.out_data, exp_data);
  endtask

  // in_ready must never be offered while a state is in flight.
  always @(negedge clk) begin
    if (rst_n && bus.busy) begin
      tests++;
      assert (bus.in_ready === 1'b0) else begin
        fails++;
        $error("FAIL ready_while_busy: observed %b expected 0", bus.in_ready);
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    logic [127:0] ins  [3];
    logic [127:0] outs [3];
    int           hold_cycles;
    tests = 0;
    fails = 0;
    ins[0] = V1_IN;  outs[0] = V1_OUT;
    ins[1] = V2_IN;  outs[1] = V2_OUT;
    ins[2] = V3_IN;  outs[2] = V3_OUT;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_bypass = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(bus.in_ready), 128'd0);
    chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
    chk("rst_out_data", bus.out_data, 128'd0);
    chk("rst_busy", 128'(bus.busy), 128'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", 128'(bus.in_ready), 128'd1);

    // Normal round, out_ready already high before DONE.
    bus.out_ready = 1'b1;
    send("t1", V1_IN, 1'b0, 1'b0);
    chk("t1_busy", 128'(bus.busy), 128'd1);
    wait_out("t1", 4, V1_OUT);
    @(posedge clk);
    #1;
    chk("t1_valid_drop", 128'(bus.out_valid), 128'd0);
    chk("t1_ready_back", 128'(bus.in_ready), 128'd1);

    // Final round bypass.
    send("t2", V1_IN, 1'b1, 1'b0);
    wait_out("t2", 1, V1_IN);
    @(posedge clk);
    #1;
    chk("t2_valid_drop", 128'(bus.out_valid), 128'd0);

    // Back-pressure for ten cycles.
    bus.out_ready = 1'b0;
    send("t3", V1_IN, 1'b0, 1'b0);
    wait_out("t3", 4, V1_OUT);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("t3_hold", {bus.out_data[127:2], bus.out_valid, bus.in_ready},
          {V1_OUT[127:2], 1'b1, 1'b0});
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t3_valid_drop", 128'(bus.out_valid), 128'd0);
    chk("t3_ready_back", 128'(bus.in_ready), 128'd1);

    // in_valid held high across two states.
    bus.out_ready = 1'b0;
    send("t4a", V2_IN, 1'b0, 1'b1);
    bus.in_data   = V3_IN;
    bus.in_bypass = 1'b0;
    wait_out("t4a", 4, V2_OUT);
    repeat (3) @(posedge clk);
    #1;
    chk("t4a_held", bus.out_data, V2_OUT);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t4_ready_after_hs", 128'(bus.in_ready), 128'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("t4b_busy", 128'(bus.busy), 128'd1);
    wait_out("t4b", 4, V3_OUT);
    @(posedge clk);
    #1;

    // Reset in the second BUSY cycle discards the partial result.
    send("t5", V1_IN, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 128'(bus.out_valid), 128'd0);
    chk("t5_rst_data", bus.out_data, 128'd0);
    chk("t5_rst_busy", 128'(bus.busy), 128'd0);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_ready", 128'(bus.in_ready), 128'd1);
    chk("t5_no_valid", 128'(bus.out_valid), 128'd0);
    send("t5b", V2_IN, 1'b0, 1'b0);
    wait_out("t5b", 4, V2_OUT);
    @(posedge clk);
    #1;

    // Mixed vectors with random output stalls.
    for (int k = 0; k < 9; k++) begin
      bus.out_ready = 1'b0;
      send("t6", ins[k % 3], 1'(k == 4), 1'b0);
      wait_out("t6", (k == 4) ? 1 : 4, (k == 4) ? ins[k % 3] : outs[k % 3]);
      hold_cycles = int'($urandom_range(0, 3));
      repeat (hold_cycles) @(posedge clk);
      #1;
      chk("t6_hold", {bus.out_data[127:1], bus.out_valid},
          {((k == 4) ? ins[k % 3][127:1] : outs[k % 3][127:1]), 1'b1});
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      chk("t6_valid_drop", 128'(bus.out_valid), 128'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
